// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Logic/add-class ops take one cycle, shifts one bit per cycle.
// Optional shift-add multiply (op 9) is enabled by defining ALU_SEQ_MUL_EN.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// EXEC  | iterating a shift or multiply, counter running down
// DONE  | result held on the output channel until out_ready
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(WIDTH);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_work;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_z;
    logic             r_n;
    logic             r_c;
    logic             r_v;
    logic             r_err;

    logic               w_accept;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic               w_slt;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_imm_res;
    logic               w_imm_c;
    logic               w_imm_v;
    logic               w_imm_err;
    logic               w_imm_exec;
    logic [CNT_W-1:0]   w_imm_cnt;
    logic [WIDTH-1:0]   w_work_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_exec_res;
    logic               w_exec_c;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;
`endif

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign flag_v    = r_v;
    assign err       = r_err;

    assign w_add   = {1'b0, a} + {1'b0, b};
    assign w_sub   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign w_slt   = $signed(a) < $signed(b);
    assign w_shamt = b[SHAMT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_imm_exec ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Single-cycle results, plus the decision to iterate and the iteration count.
    always_comb begin
        w_imm_res  = '0;
        w_imm_c    = 1'b0;
        w_imm_v    = 1'b0;
        w_imm_err  = 1'b0;
        w_imm_exec = 1'b0;
        w_imm_cnt  = '0;
        case (op)
            OP_ADD: begin
                w_imm_res = w_add[WIDTH-1:0];
                w_imm_c   = w_add[WIDTH];
                w_imm_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_imm_res = w_sub[WIDTH-1:0];
                w_imm_c   = w_sub[WIDTH];
                w_imm_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_imm_res = a & b;
            OP_OR:  w_imm_res = a | b;
            OP_XOR: w_imm_res = a ^ b;
            OP_SLT: w_imm_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLL, OP_SRL, OP_SRA: begin
                if (w_shamt == '0) begin
                    w_imm_res = a;
                end else begin
                    w_imm_exec = 1'b1;
                    w_imm_cnt  = {1'b0, w_shamt};
                end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                w_imm_exec = 1'b1;
                w_imm_cnt  = MUL_CNT;
            end
`endif
            default: w_imm_err = 1'b1;
        endcase
    end

    always_comb begin
        w_work_next = r_work;
        case (r_op)
            OP_SLL:  w_work_next = {r_work[WIDTH-2:0], 1'b0};
            OP_SRL:  w_work_next = {1'b0, r_work[WIDTH-1:1]};
            OP_SRA:  w_work_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_work_next = r_work;
        endcase
    end

    assign w_last = (r_cnt == CNT_W'(1));

`ifdef ALU_SEQ_MUL_EN
    // Multiplier sits in the low half; partial product shifts in from the top.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_work} : '0);
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif

    always_comb begin
        w_exec_res = w_work_next;
        w_exec_c   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        if (r_op == OP_MUL) begin
            w_exec_res = w_acc_next[WIDTH-1:0];
            w_exec_c   = |w_acc_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_work   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_acc    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= op;
                        r_work <= a;
                        r_cnt  <= w_imm_cnt;
`ifdef ALU_SEQ_MUL_EN
                        r_acc  <= {{WIDTH{1'b0}}, b};
`endif
                        if (!w_imm_exec) begin
                            r_result <= w_imm_res;
                            r_z      <= (w_imm_res == '0);
                            r_n      <= w_imm_res[WIDTH-1];
                            r_c      <= w_imm_c;
                            r_v      <= w_imm_v;
                            r_err    <= w_imm_err;
                        end
                    end
                end
                S_EXEC: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
                    r_acc  <= w_acc_next;
`endif
                    if (w_last) begin
                        r_result <= w_exec_res;
                        r_z      <= (w_exec_res == '0);
                        r_n      <= w_exec_res[WIDTH-1];
                        r_c      <= w_exec_c;
                        r_v      <= 1'b0;
                        r_err    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v, err;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .flag_v(flag_v), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one op while idle; returns in the first cycle out_valid is seen.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat);
        in_valid = 1'b1; op = o; a = x; b = y;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL timeout op=%0d: out_valid never rose within %0d cycles", o, lat);
        end
        checks++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL reset_hs: in_ready/out_valid=%b want 10", {in_ready, out_valid}); end
        checks++;
        if ({result, flag_z, flag_n, flag_c, flag_v, err} !== 13'd0) begin errors++; $display("FAIL reset_out: result=%h flags=%b err=%b want zeros", result, {flag_z, flag_n, flag_c, flag_v}, err); end
        checks++;
    endtask

    task automatic test_add_class();
        int lat;
        run_op(4'd0, 8'd10, 8'd5, lat);
        if (lat !== 1) begin errors++; $display("FAIL add_lat: got %0d want 1", lat); end
        checks++;
        if ({result, flag_z, flag_n, flag_c, flag_v, err} !== {8'd15, 4'b0000, 1'b0}) begin errors++; $display("FAIL add_res: result=%0d zncv=%b err=%b want 15 0000 0", result, {flag_z, flag_n, flag_c, flag_v}, err); end
        checks++;
        tick();
        if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: in_ready=%b want 1", in_ready); end
        checks++;

        run_op(4'd1, 8'd5, 8'd10, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'd251, 4'b0100}) begin errors++; $display("FAIL sub_neg: result=%0d zncv=%b want 251 0100", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd1, 8'h80, 8'h01, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h7F, 4'b0011}) begin errors++; $display("FAIL sub_ovf: result=%h zncv=%b want 7f 0011", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd0, 8'h7F, 8'h01, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h80, 4'b0101}) begin errors++; $display("FAIL add_ovf: result=%h zncv=%b want 80 0101", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd0, 8'hFF, 8'h01, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h00, 4'b1010}) begin errors++; $display("FAIL add_carry: result=%h zncv=%b want 00 1010", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd2, 8'hF0, 8'h0F, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h00, 4'b1000}) begin errors++; $display("FAIL and: result=%h zncv=%b want 00 1000", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd3, 8'h80, 8'h01, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h81, 4'b0100}) begin errors++; $display("FAIL or: result=%h zncv=%b want 81 0100", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd4, 8'hA5, 8'hFF, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h5A, 4'b0000}) begin errors++; $display("FAIL xor: result=%h zncv=%b want 5a 0000", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd5, 8'hFF, 8'h01, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h01, 4'b0000}) begin errors++; $display("FAIL slt_true: result=%h zncv=%b want 01 0000", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd5, 8'h01, 8'hFF, lat);
        if ({result, flag_z} !== {8'h00, 1'b1}) begin errors++; $display("FAIL slt_false: result=%h z=%b want 00 1", result, flag_z); end
        checks++;
        tick();
    endtask

    task automatic test_shift();
        int lat;
        run_op(4'd6, 8'd10, 8'd5, lat);
        if ({lat[7:0], result, flag_z, flag_n, flag_c, flag_v} !== {8'd6, 8'd64, 4'b0000}) begin errors++; $display("FAIL sll: lat=%0d result=%0d zncv=%b want 6 64 0000", lat, result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd8, 8'h80, 8'd3, lat);
        if ({lat[7:0], result, flag_z, flag_n, flag_c, flag_v} !== {8'd4, 8'hF0, 4'b0100}) begin errors++; $display("FAIL sra: lat=%0d result=%h zncv=%b want 4 f0 0100", lat, result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
        run_op(4'd7, 8'h96, 8'd0, lat);
        if ({lat[7:0], result, flag_n} !== {8'd1, 8'h96, 1'b1}) begin errors++; $display("FAIL srl0: lat=%0d result=%h n=%b want 1 96 1", lat, result, flag_n); end
        checks++;
        tick();
        run_op(4'd7, 8'h80, 8'd7, lat);
        if ({lat[7:0], result, flag_n} !== {8'd8, 8'h01, 1'b0}) begin errors++; $display("FAIL srl7: lat=%0d result=%h n=%b want 8 01 0", lat, result, flag_n); end
        checks++;
        tick();
        run_op(4'd6, 8'h01, 8'h11, lat);
        if ({lat[7:0], result} !== {8'd2, 8'h02}) begin errors++; $display("FAIL sll_mask: lat=%0d result=%h want 2 02", lat, result); end
        checks++;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 8'd10; b = 8'd5;
        tick();
        op = 4'd0; a = 8'd1; b = 8'd1;
        for (int i = 0; i < 4; i++) begin
            if ({out_valid, in_ready, result, flag_z, flag_n, flag_c, flag_v} !== {2'b10, 8'd15, 4'b0000}) begin errors++; $display("FAIL bp_hold%0d: valid=%b ready=%b result=%0d zncv=%b want 1 0 15 0000", i, out_valid, in_ready, result, {flag_z, flag_n, flag_c, flag_v}); end
            checks++;
            if (i == 3) out_ready = 1'b1;
            tick();
        end
        if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: valid=%b ready=%b want 0 1", out_valid, in_ready); end
        checks++;
        tick();
        in_valid = 1'b0;
        if ({out_valid, result} !== {1'b1, 8'd2}) begin errors++; $display("FAIL bp_next: valid=%b result=%0d want 1 2", out_valid, result); end
        checks++;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        in_valid = 1'b1; op = 4'd6; a = 8'd1; b = 8'd7;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err} !== {2'b10, 13'd0}) begin errors++; $display("FAIL rst_mid: ready=%b valid=%b result=%h flags=%b err=%b want 1 0 00 0000 0", in_ready, out_valid, result, {flag_z, flag_n, flag_c, flag_v}, err); end
        checks++;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        if (seen !== 0) begin errors++; $display("FAIL rst_no_out: out_valid seen %0d cycles want 0", seen); end
        checks++;
        run_op(4'd0, 8'd1, 8'd1, lat);
        if ({lat[7:0], result} !== {8'd1, 8'd2}) begin errors++; $display("FAIL rst_after_add: lat=%0d result=%0d want 1 2", lat, result); end
        checks++;
        tick();
    endtask

    task automatic test_mul();
        int lat;
`ifdef ALU_SEQ_MUL_EN
        run_op(4'd9, 8'd10, 8'd5, lat);
        if ({lat[7:0], result, flag_z, flag_n, flag_c, flag_v, err} !== {8'd9, 8'd50, 4'b0000, 1'b0}) begin errors++; $display("FAIL mul: lat=%0d result=%0d zncv=%b err=%b want 9 50 0000 0", lat, result, {flag_z, flag_n, flag_c, flag_v}, err); end
        checks++;
        tick();
        run_op(4'd9, 8'd16, 8'd16, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v, err} !== {8'd0, 4'b1010, 1'b0}) begin errors++; $display("FAIL mul_hi: result=%0d zncv=%b err=%b want 0 1010 0", result, {flag_z, flag_n, flag_c, flag_v}, err); end
        checks++;
        tick();
        run_op(4'd9, 8'hFF, 8'hFF, lat);
        if ({result, flag_z, flag_n, flag_c, flag_v} !== {8'h01, 4'b0010}) begin errors++; $display("FAIL mul_ff: result=%h zncv=%b want 01 0010", result, {flag_z, flag_n, flag_c, flag_v}); end
        checks++;
        tick();
`else
        run_op(4'd9, 8'd10, 8'd5, lat);
        if ({lat[7:0], result, flag_z, flag_n, flag_c, flag_v, err} !== {8'd1, 8'd0, 4'b1000, 1'b1}) begin errors++; $display("FAIL mul_off: lat=%0d result=%0d zncv=%b err=%b want 1 0 1000 1", lat, result, {flag_z, flag_n, flag_c, flag_v}, err); end
        checks++;
        tick();
`endif
    endtask

    task automatic test_illegal();
        int lat;
        run_op(4'd15, 8'd3, 8'd4, lat);
        if ({lat[7:0], result, flag_z, flag_n, flag_c, flag_v, err} !== {8'd1, 8'd0, 4'b1000, 1'b1}) begin errors++; $display("FAIL illegal: lat=%0d result=%0d zncv=%b err=%b want 1 0 1000 1", lat, result, {flag_z, flag_n, flag_c, flag_v}, err); end
        checks++;
        tick();
        run_op(4'd0, 8'd2, 8'd2, lat);
        if ({result, err} !== {8'd4, 1'b0}) begin errors++; $display("FAIL err_clear: result=%0d err=%b want 4 0", result, err); end
        checks++;
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        in_valid = 1'b1; op = 4'd0; a = 8'd2; b = 8'd3;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        in_valid = 1'b0;
        if ({pulses[7:0], result} !== {8'd4, 8'd5}) begin errors++; $display("FAIL b2b: pulses=%0d result=%0d want 4 5", pulses, result); end
        checks++;
        repeat (2) tick();
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: in_ready=%b want 1", in_ready); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_add_class();
        test_shift();
        test_backpressure();
        test_reset_mid();
        test_mul();
        test_illegal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
